// File: rtl/z_multiplier_pipe.sv
// ---------------------------------------------------------------------------
// z_multiplier_pipe
//
// Pipelined fixed-point complex multiplier for the FFT datapath. It sits
// between the butterfly adder stage and the twiddle ROM. For each transaction
// it computes Y = A*B, or Y = A*conj(B) when conj_b is set. The product is
// shifted right by FRAC, rounded half-up (ties go toward +inf) and saturated
// back to WIDTH bits.
//
// Pipeline:
//   S1 - operand registers (ar, ai, br, bi, conj_b)
//   S2 - the four full-width partial products
//   S3 - rounded, saturated result (yr, yi, sat, out_valid)
//
// Flow control is plain valid/ready. A stall is a held result that downstream
// is not taking. During a stall the whole pipeline freezes. Otherwise every
// stage advances each cycle. There is no skid storage, so in_ready is a
// purely combinational function of out_valid and out_ready.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      A, B, conj_b valid this cycle
//   in_ready   out  1      block accepts input this cycle
//   ar, ai     in   WIDTH  operand A real/imag, signed
//   br, bi     in   WIDTH  operand B real/imag, signed Q(WIDTH-FRAC).FRAC
//   conj_b     in   1      1: compute A*conj(B)
//   out_valid  out  1      yr, yi, sat valid
//   out_ready  in   1      downstream accepts output
//   yr, yi     out  WIDTH  result real/imag, signed
//   sat        out  1      yr or yi was clipped for this result
// ---------------------------------------------------------------------------
module z_multiplier_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] ar,
    input  logic signed [WIDTH-1:0] ai,
    input  logic signed [WIDTH-1:0] br,
    input  logic signed [WIDTH-1:0] bi,
    input  logic                    conj_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] yr,
    output logic signed [WIDTH-1:0] yi,
    output logic                    sat
);

    // Product width and accumulation width. One extra bit above the product
    // width means the sum or difference of two products can never wrap.
    localparam int PW = 2 * WIDTH;
    localparam int XW = PW + 1;

    // Half an output LSB, added before the arithmetic shift for round-half-up.
    localparam logic [XW-1:0] RND = {{(XW-1){1'b0}}, 1'b1} << (FRAC - 1);

    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    // Sign-extend an operand to the product width. The low PW bits of an
    // unsigned PW x PW multiply then equal the signed product.
    function automatic logic [PW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    // Round and saturate one component. Returns {clipped, value}.
    // After the shift, the value fits in WIDTH bits only when all bits from
    // the sign bit down to bit WIDTH-1 agree. A positive value with any of
    // those bits set is too big. A negative value with any of them clear is
    // too small.
    function automatic logic [WIDTH:0] round_sat(input logic [XW-1:0] x);
        logic signed [XW-1:0] xr;
        logic signed [XW-1:0] y;
        logic                 hi;
        logic                 lo;
        xr = $signed(x + RND);
        y  = xr >>> FRAC;
        hi = ~y[XW-1] & (|y[XW-2:WIDTH-1]);
        lo =  y[XW-1] & ~(&y[XW-2:WIDTH-1]);
        if (hi) begin
            return {1'b1, MAXV};
        end else if (lo) begin
            return {1'b1, MINV};
        end else begin
            return {1'b0, y[WIDTH-1:0]};
        end
    endfunction

    // Stage registers
    logic                    s1_valid;
    logic [WIDTH-1:0]        s1_ar;
    logic [WIDTH-1:0]        s1_ai;
    logic [WIDTH-1:0]        s1_br;
    logic [WIDTH-1:0]        s1_bi;
    logic                    s1_conj;

    logic                    s2_valid;
    logic [PW-1:0]           s2_prr;
    logic [PW-1:0]           s2_pii;
    logic [PW-1:0]           s2_pri;
    logic [PW-1:0]           s2_pir;
    logic                    s2_conj;

    logic                    advance;
    logic [XW-1:0]           x_re;
    logic [XW-1:0]           x_im;
    logic [WIDTH:0]          res_re;
    logic [WIDTH:0]          res_im;

    // A stall is a valid result that downstream refuses. Nothing may move
    // while it sits there, so the input side is refused in the same cycle.
    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;

    // Combine the S2 products at XW bits, then round and saturate. The
    // conjugate case flips the sign of bi, which swaps the sign of the two
    // terms that contain it.
    always_comb begin
        logic [XW-1:0] e_rr;
        logic [XW-1:0] e_ii;
        logic [XW-1:0] e_ri;
        logic [XW-1:0] e_ir;
        e_rr = {s2_prr[PW-1], s2_prr};
        e_ii = {s2_pii[PW-1], s2_pii};
        e_ri = {s2_pri[PW-1], s2_pri};
        e_ir = {s2_pir[PW-1], s2_pir};
        x_re = e_rr - e_ii;
        x_im = e_ri + e_ir;
        if (s2_conj) begin
            x_re = e_rr + e_ii;
            x_im = e_ir - e_ri;
        end
        res_re = round_sat(x_re);
        res_im = round_sat(x_im);
    end

    // Pipeline register update. Reset clears every valid bit and the visible
    // outputs. The internal data registers are don't-care until their valid
    // bit is set. While stalled, all stages keep their contents. Results are
    // only loaded into S3 for real transactions, so bubbles do not disturb
    // the last value seen on yr/yi/sat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            yr        <= '0;
            yi        <= '0;
            sat       <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_ar    <= ar;
            s1_ai    <= ai;
            s1_br    <= br;
            s1_bi    <= bi;
            s1_conj  <= conj_b;

            s2_valid <= s1_valid;
            s2_prr   <= sext(s1_ar) * sext(s1_br);
            s2_pii   <= sext(s1_ai) * sext(s1_bi);
            s2_pri   <= sext(s1_ar) * sext(s1_bi);
            s2_pir   <= sext(s1_ai) * sext(s1_br);
            s2_conj  <= s1_conj;

            out_valid <= s2_valid;
            if (s2_valid) begin
                yr  <= res_re[WIDTH-1:0];
                yi  <= res_im[WIDTH-1:0];
                sat <= res_re[WIDTH] | res_im[WIDTH];
            end
        end
    end

endmodule
